systolic_ctrl: RTL

Sequencing controller for one `systolic_array` layer instance:
- Fetches the layer's weights from a weight memory and shifts them into the array, then pulses the array's weight-latch enable.
- Accepts rows of the input matrix over a valid/ready handshake and skews them into the diagonal format the array consumes. Also generates the array's `in_start`/`in_valid`.
- Flushes the pipeline with zero beats and reports completion.

It sits between the row producer (previous layer or input buffer) and the array.

---
 rtl/systolic_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// Sequencing controller for one systolic_array layer: loads weights, skews
// input rows into diagonal order, flushes the array with zero beats.
module systolic_ctrl #(
   parameter int unsigned BitSize     = 8,
   parameter int unsigned M_W_BitSize = 4,
   parameter int unsigned NumOfInputs = 2,
   parameter int unsigned NumOfNerves = 2,
   parameter int unsigned MaxRows     = 16
) (
   input  logic                                  clk,
   input  logic                                  res,
   input  logic                                  cfg_start,
   input  logic [$clog2(MaxRows+1)-1:0]          cfg_rows,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  w_rd_en,
   output logic [$clog2(NumOfInputs)-1:0]        w_addr,
   input  logic [NumOfNerves*M_W_BitSize-1:0]    w_rd_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [NumOfInputs*BitSize-1:0]        in_data,
   output logic                                  sa_en_l_b,
   output logic [NumOfNerves*M_W_BitSize-1:0]    sa_weights,
   output logic                                  sa_valid,
   output logic                                  sa_start,
   output logic [NumOfInputs*BitSize-1:0]        sa_data
);

   localparam int unsigned RW          = $clog2(MaxRows + 1);
   localparam int unsigned AW          = $clog2(NumOfInputs);
   localparam int unsigned DRAIN_BEATS = NumOfInputs + NumOfNerves;
   localparam int unsigned DW          = $clog2(DRAIN_BEATS);
   localparam int unsigned LW          = NumOfInputs * BitSize;
   localparam int unsigned TOP         = NumOfInputs - 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LATCH,
      STREAM,
      DRAIN,
      FIN
   } state_t;

   state_t        state;
   logic [RW-1:0] rows;
   logic [RW-1:0] row_cnt;
   logic [DW-1:0] drain_cnt;

   logic          stream;
   logic          accept;
   logic          beat;
   logic [LW-1:0] push;
   logic [LW-1:0] beat_data;
   logic [LW-1:0] data_hold;

   // Beat qualification: accepted rows in STREAM, every cycle in DRAIN.
   assign stream    = (state == STREAM);
   assign in_ready  = stream;
   assign accept    = stream && in_valid;
   assign beat      = accept || (state == DRAIN);
   assign sa_valid  = beat;
   assign sa_start  = accept && (row_cnt == '0);
   assign push      = stream ? in_data : '0;

   // Sequencing FSM; all state-side outputs are registered here.
   always_ff @(posedge clk) begin
      if (res) begin
         state     <= IDLE;
         rows      <= '0;
         row_cnt   <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         w_rd_en   <= 1'b0;
         w_addr    <= '0;
         sa_en_l_b <= 1'b0;
      end else begin
         done      <= 1'b0;
         w_rd_en   <= 1'b0;
         sa_en_l_b <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start && (cfg_rows != '0)) begin
                  state     <= LOAD_W;
                  rows      <= cfg_rows;
                  row_cnt   <= '0;
                  drain_cnt <= '0;
                  busy      <= 1'b1;
                  w_rd_en   <= 1'b1;
                  w_addr    <= '0;
               end
            end
            LOAD_W: begin
               if (w_addr == AW'(NumOfInputs - 1)) begin
                  state     <= LATCH;
                  w_addr    <= '0;
                  sa_en_l_b <= 1'b1;
               end else begin
                  w_rd_en <= 1'b1;
                  w_addr  <= w_addr + AW'(1);
               end
            end
            LATCH: begin
               state <= STREAM;
            end
            STREAM: begin
               if (in_valid) begin
                  row_cnt <= row_cnt + RW'(1);
                  if (row_cnt == rows - RW'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Counter stops at its terminal value instead of wrapping.
               if (drain_cnt == DW'(DRAIN_BEATS - 1)) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Weight row register follows the memory read port every cycle.
   always_ff @(posedge clk) begin
      if (res) begin
         sa_weights <= '0;
      end else begin
         sa_weights <= w_rd_data;
      end
   end

   // Lane k is delayed by TOP-k beats; the top lane passes straight through.
   for (genvar k = 0; k < TOP; k++) begin : g_skew
      localparam int unsigned D = TOP - k;
      logic [BitSize-1:0] line [D];

      always_ff @(posedge clk) begin
         if (res) begin
            for (int unsigned j = 0; j < D; j++) begin
               line[j] <= '0;
            end
         end else if (beat) begin
            line[0] <= push[k*BitSize +: BitSize];
            for (int unsigned j = 1; j < D; j++) begin
               line[j] <= line[j-1];
            end
         end
      end

      assign beat_data[k*BitSize +: BitSize] = line[D-1];
   end

   assign beat_data[TOP*BitSize +: BitSize] = push[TOP*BitSize +: BitSize];

   // Between beats the array is frozen, so the whole skewed row is held.
   always_ff @(posedge clk) begin
      if (res) begin
         data_hold <= '0;
      end else if (beat) begin
         data_hold <= beat_data;
      end
   end

   assign sa_data = beat ? beat_data : data_hold;

endmodule
